// File: rtl/ctrl_cmd_rx.sv
// rtl/ctrl_cmd_rx.sv - nibble-serial command packet receiver with shadow assembly and inter-nibble timeout
// Optional trailing XOR parity nibble enabled by defining CTRL_CMD_RX_PARITY_EN.
module ctrl_cmd_rx #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  nib_data,
    input  logic        nib_valid,
    output logic        nib_ready,
    output logic [4:0]  cmd,
    output logic [13:0] x_value,
    output logic [13:0] y_value,
    output logic        cmd_valid,
    input  logic        cmd_ack,
    output logic        frame_err
);

`ifdef CTRL_CMD_RX_PARITY_EN
    localparam logic [3:0] LAST_IDX = 4'd10;
`else
    localparam logic [3:0] LAST_IDX = 4'd9;
`endif
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RECV, HOLD} state_t;

    state_t      state, next_state;
    logic [3:0]  idx;
    logic [15:0] idle_cnt;
    logic [4:0]  sh_cmd, nxt_cmd;
    logic [13:0] sh_x, nxt_x;
    logic [13:0] sh_y, nxt_y;
    logic        sh_bad, nxt_bad;
    logic        rsv_bad, pkt_bad;
    logic        accept, timeout_hit, do_load, drop;
`ifdef CTRL_CMD_RX_PARITY_EN
    logic [3:0]  sh_par, nxt_par;
`endif

    assign accept      = nib_valid && nib_ready;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (idle_cnt == TO_LAST);
    assign cmd_valid   = (state == HOLD);

    // Merge the incoming nibble into a copy of the shadow fields; the output
    // registers load from this copy so the last nibble lands on the same edge.
    always_comb begin
        nxt_cmd = sh_cmd;
        nxt_x   = sh_x;
        nxt_y   = sh_y;
        rsv_bad = 1'b0;
        case (idx)
            4'd0: nxt_cmd[3:0]  = nib_data;
            4'd1: begin
                nxt_cmd[4] = nib_data[0];
                rsv_bad    = (nib_data[3:1] != 3'd0);
            end
            4'd2: nxt_x[3:0]    = nib_data;
            4'd3: nxt_x[7:4]    = nib_data;
            4'd4: nxt_x[11:8]   = nib_data;
            4'd5: begin
                nxt_x[13:12] = nib_data[1:0];
                rsv_bad      = (nib_data[3:2] != 2'd0);
            end
            4'd6: nxt_y[3:0]    = nib_data;
            4'd7: nxt_y[7:4]    = nib_data;
            4'd8: nxt_y[11:8]   = nib_data;
            4'd9: begin
                nxt_y[13:12] = nib_data[1:0];
                rsv_bad      = (nib_data[3:2] != 2'd0);
            end
            default: ;
        endcase
        nxt_bad = ((idx == 4'd0) ? 1'b0 : sh_bad) || rsv_bad;
`ifdef CTRL_CMD_RX_PARITY_EN
        nxt_par = ((idx == 4'd0) ? 4'h0 : sh_par) ^ nib_data;
        pkt_bad = nxt_bad || (idx == LAST_IDX && nib_data != sh_par);
`else
        pkt_bad = nxt_bad;
`endif
    end

    always_comb begin
        next_state = state;
        do_load    = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: if (accept) next_state = RECV;
            RECV: begin
                if (accept && idx == LAST_IDX) begin
                    if (pkt_bad) begin
                        drop       = 1'b1;
                        next_state = IDLE;
                    end else begin
                        do_load    = 1'b1;
                        next_state = HOLD;
                    end
                end else if (!accept && timeout_hit) begin
                    drop       = 1'b1;
                    next_state = IDLE;
                end
            end
            HOLD: if (cmd_ack) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 4'd0;
            idle_cnt  <= 16'd0;
            nib_ready <= 1'b0;
            frame_err <= 1'b0;
            sh_cmd    <= 5'd0;
            sh_x      <= 14'd0;
            sh_y      <= 14'd0;
            sh_bad    <= 1'b0;
            cmd       <= 5'd0;
            x_value   <= 14'd0;
            y_value   <= 14'd0;
`ifdef CTRL_CMD_RX_PARITY_EN
            sh_par    <= 4'h0;
`endif
        end else begin
            state     <= next_state;
            nib_ready <= (next_state != HOLD);
            frame_err <= drop;
            if (accept) begin
                sh_cmd   <= nxt_cmd;
                sh_x     <= nxt_x;
                sh_y     <= nxt_y;
                sh_bad   <= nxt_bad;
`ifdef CTRL_CMD_RX_PARITY_EN
                sh_par   <= nxt_par;
`endif
                idx      <= idx + 4'd1;
                idle_cnt <= 16'd0;
            end else if (state == RECV) begin
                idle_cnt <= idle_cnt + 16'd1;
            end
            if (next_state != RECV) begin
                idx      <= 4'd0;
                idle_cnt <= 16'd0;
            end
            if (do_load) begin
                cmd     <= nxt_cmd;
                x_value <= nxt_x;
                y_value <= nxt_y;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_cmd_rx.sv
// tb/tb_ctrl_cmd_rx.sv - directed, table-driven bench for ctrl_cmd_rx
module tb_ctrl_cmd_rx;

`ifdef CTRL_CMD_RX_PARITY_EN
    localparam int NLEN = 11;
`else
    localparam int NLEN = 10;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  nib_data;
    logic        nib_valid;
    logic        nib_ready;
    logic [4:0]  cmd;
    logic [13:0] x_value;
    logic [13:0] y_value;
    logic        cmd_valid;
    logic        cmd_ack;
    logic        frame_err;

    ctrl_cmd_rx #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .nib_data(nib_data), .nib_valid(nib_valid),
        .nib_ready(nib_ready), .cmd(cmd), .x_value(x_value), .y_value(y_value),
        .cmd_valid(cmd_valid), .cmd_ack(cmd_ack), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  cmd;
        logic [13:0] x;
        logic [13:0] y;
        int          bad_idx;
        logic [3:0]  bad_val;
    } vec_t;

    vec_t        vecs[$];
    logic [3:0]  pkt[11];
    logic [4:0]  exp_cmd;
    logic [13:0] exp_x, exp_y;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] c, input logic [13:0] x, input logic [13:0] y,
                                input int bi, input logic [3:0] bv);
        vec_t v;
        v.cmd = c; v.x = x; v.y = y; v.bad_idx = bi; v.bad_val = bv;
        return v;
    endfunction

    task automatic fill(input vec_t v);
        pkt[0] = v.cmd[3:0];
        pkt[1] = {3'b000, v.cmd[4]};
        pkt[2] = v.x[3:0];
        pkt[3] = v.x[7:4];
        pkt[4] = v.x[11:8];
        pkt[5] = {2'b00, v.x[13:12]};
        pkt[6] = v.y[3:0];
        pkt[7] = v.y[7:4];
        pkt[8] = v.y[11:8];
        pkt[9] = {2'b00, v.y[13:12]};
        pkt[10] = 4'h0;
        for (int i = 0; i < 10; i++) pkt[10] = pkt[10] ^ pkt[i];
        if (v.bad_idx == 10) pkt[10] = pkt[10] ^ v.bad_val;
        else if (v.bad_idx != 0) pkt[v.bad_idx] = v.bad_val;
    endtask

    // Returns #1 after the accepting edge so back-to-back calls transfer on consecutive edges.
    task automatic send_nib(input logic [3:0] n);
        int t;
        t = 0;
        nib_data  = n;
        nib_valid = 1'b1;
        while (!nib_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) chk("nib_accept_wait", 0, 1);
        @(posedge clk); #1;
        nib_valid = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_cmd"}, cmd, exp_cmd);
        chk({tag, "_x"}, x_value, exp_x);
        chk({tag, "_y"}, y_value, exp_y);
    endtask

    task automatic send_pkt(input vec_t v, input bit do_ack);
        fill(v);
        for (int i = 0; i < NLEN; i++) send_nib(pkt[i]);
        if (v.bad_idx == 0) begin
            exp_cmd = v.cmd; exp_x = v.x; exp_y = v.y;
            chk("good_cmd_valid", cmd_valid, 1);
            chk("good_nib_ready", nib_ready, 0);
            chk("good_frame_err", frame_err, 0);
            check_outputs("good");
            if (do_ack) begin
                cmd_ack = 1'b1;
                @(posedge clk); #1;
                cmd_ack = 1'b0;
                chk("ack_cmd_valid", cmd_valid, 0);
                chk("ack_nib_ready", nib_ready, 1);
                check_outputs("ack_retain");
            end
        end else begin
            chk("bad_frame_err", frame_err, 1);
            chk("bad_cmd_valid", cmd_valid, 0);
            chk("bad_nib_ready", nib_ready, 1);
            check_outputs("bad_retain");
            @(posedge clk); #1;
            chk("bad_frame_err_once", frame_err, 0);
        end
    endtask

    initial begin
        int cyc;
        vecs.push_back(mk(5'h13, 14'h2ABC, 14'h0123, 0, 4'h0));
        vecs.push_back(mk(5'h00, 14'h0000, 14'h0000, 0, 4'h0));
        vecs.push_back(mk(5'h1F, 14'h3FFF, 14'h3FFF, 0, 4'h0));
        vecs.push_back(mk(5'h05, 14'h1234, 14'h0567, 5, 4'h6));
        vecs.push_back(mk(5'h0A, 14'h1111, 14'h2222, 0, 4'h0));
        vecs.push_back(mk(5'h11, 14'h0001, 14'h0002, 1, 4'h2));
        vecs.push_back(mk(5'h07, 14'h0F0F, 14'h30F0, 9, 4'h4));
        vecs.push_back(mk(5'h16, 14'h2468, 14'h1357, 0, 4'h0));
`ifdef CTRL_CMD_RX_PARITY_EN
        vecs.push_back(mk(5'h09, 14'h0AAA, 14'h1555, 10, 4'h1));
        vecs.push_back(mk(5'h09, 14'h0AAA, 14'h1555, 0, 4'h0));
`endif

        reset = 1'b1; nib_valid = 1'b0; nib_data = 4'h0; cmd_ack = 1'b0;
        exp_cmd = 5'h0; exp_x = 14'h0; exp_y = 14'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_nib_ready", nib_ready, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        check_outputs("rst");
        @(negedge clk); reset = 1'b0;
        #1 chk("rel_nib_ready_before_edge", nib_ready, 0);
        @(posedge clk); #1;
        chk("rel_nib_ready_first_edge", nib_ready, 1);

        // ack while nothing is held is ignored
        cmd_ack = 1'b1;
        @(posedge clk); #1;
        cmd_ack = 1'b0;
        chk("idle_ack_cmd_valid", cmd_valid, 0);
        chk("idle_ack_nib_ready", nib_ready, 1);

        foreach (vecs[i]) send_pkt(vecs[i], 1'b1);

        // sender stalls against a held packet
        send_pkt(mk(5'h13, 14'h2ABC, 14'h0123, 0, 4'h0), 1'b0);
        nib_data = 4'h5; nib_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("hold_nib_ready", nib_ready, 0);
            chk("hold_cmd_valid", cmd_valid, 1);
            check_outputs("hold");
        end
        cmd_ack = 1'b1;
        @(posedge clk); #1;
        cmd_ack = 1'b0; nib_valid = 1'b0;
        chk("hold_ack_cmd_valid", cmd_valid, 0);
        chk("hold_ack_nib_ready", nib_ready, 1);

        // inter-nibble timeout after nibble 4
        fill(mk(5'h1E, 14'h0ABC, 14'h0DEF, 0, 4'h0));
        for (int i = 0; i < 5; i++) send_nib(pkt[i]);
        cyc = 0;
        while (!frame_err && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("timeout_cycles", cyc, 8);
        chk("timeout_nib_ready", nib_ready, 1);
        chk("timeout_cmd_valid", cmd_valid, 0);
        check_outputs("timeout_retain");
        @(posedge clk); #1;
        chk("timeout_frame_err_once", frame_err, 0);
        send_pkt(mk(5'h1E, 14'h0ABC, 14'h0DEF, 0, 4'h0), 1'b1);

        // reset in the middle of a packet
        fill(mk(5'h02, 14'h3333, 14'h0444, 0, 4'h0));
        for (int i = 0; i < 7; i++) send_nib(pkt[i]);
        reset = 1'b1;
        #1;
        exp_cmd = 5'h0; exp_x = 14'h0; exp_y = 14'h0;
        chk("midrst_nib_ready", nib_ready, 0);
        chk("midrst_cmd_valid", cmd_valid, 0);
        chk("midrst_frame_err", frame_err, 0);
        check_outputs("midrst");
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("midrst_rel_nib_ready", nib_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_frame_err", frame_err, 0);
        end
        send_pkt(mk(5'h02, 14'h3333, 14'h0444, 0, 4'h0), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
